// File: rtl/grf_wb_buffer.sv
// ============================================================================
// Module   : grf_wb_buffer
// Brief    : GRF write-back queue merging ALU and MDU register writes in order,
//            one write issued per cycle, with a pending-destination scoreboard.
//            Optional macro WB_TRACE_EN prints every issued write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module grf_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_a3,
    input  logic [DATA_W-1:0]          alu_wd,
    input  logic [DATA_W-1:0]          alu_pc,
    input  logic                       mdu_valid,
    output logic                       mdu_ready,
    input  logic [4:0]                 mdu_a3,
    input  logic [DATA_W-1:0]          mdu_wd,
    input  logic [DATA_W-1:0]          mdu_pc,
    output logic                       regwrite,
    output logic [4:0]                 A3,
    output logic [DATA_W-1:0]          WD,
    output logic [DATA_W-1:0]          pc,
    input  logic [4:0]                 q_a1,
    input  logic [4:0]                 q_a2,
    output logic                       q_busy1,
    output logic                       q_busy2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [4:0]        r_a3 [DEPTH];
    logic [DATA_W-1:0] r_wd [DEPTH];
    logic [DATA_W-1:0] r_pc [DEPTH];

    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_regwrite;
    logic [4:0]        r_A3;
    logic [DATA_W-1:0] r_WD;
    logic [DATA_W-1:0] r_pc_out;

    logic [CNT_W-1:0]  w_free;
    logic              w_alu_nz;
    logic              w_mdu_nz;
    logic              w_alu_room;
    logic              w_mdu_room;
    logic              w_alu_push;
    logic              w_mdu_push;
    logic              w_pop;
    logic [1:0]        w_npush;
    logic [PTR_W-1:0]  w_mdu_idx;
    logic [DEPTH-1:0]  w_hit1;
    logic [DEPTH-1:0]  w_hit2;

    // Credit is based on the current occupancy only; a same-edge pop is not counted.
    assign w_free     = C_DEPTH - r_count;
    assign w_alu_nz   = (alu_a3 != 5'd0);
    assign w_mdu_nz   = (mdu_a3 != 5'd0);
    assign w_alu_room = (w_free != '0);
    assign w_mdu_room = (w_free > CNT_W'(1)) ||
                        ((w_free != '0) && !(alu_valid && w_alu_nz));

    // Writes to $0 are always accepted and silently dropped.
    assign alu_ready  = !w_alu_nz || w_alu_room;
    assign mdu_ready  = !w_mdu_nz || w_mdu_room;

    assign w_alu_push = alu_valid && w_alu_nz && w_alu_room;
    assign w_mdu_push = mdu_valid && w_mdu_nz && w_mdu_room;
    assign w_pop      = (r_count != '0);
    assign w_npush    = {1'b0, w_alu_push} + {1'b0, w_mdu_push};
    assign w_mdu_idx  = w_alu_push ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_regwrite <= 1'b0;
            r_A3       <= '0;
            r_WD       <= '0;
            r_pc_out   <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_npush);
            r_count    <= r_count + CNT_W'(w_npush) - CNT_W'(w_pop);
            r_regwrite <= w_pop;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_A3     <= r_a3[r_rd_ptr];
                r_WD     <= r_wd[r_rd_ptr];
                r_pc_out <= r_pc[r_rd_ptr];
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_a3[r_wr_ptr] <= alu_a3;
            r_wd[r_wr_ptr] <= alu_wd;
            r_pc[r_wr_ptr] <= alu_pc;
        end
        if (w_mdu_push) begin
            r_a3[w_mdu_idx] <= mdu_a3;
            r_wd[w_mdu_idx] <= mdu_wd;
            r_pc[w_mdu_idx] <= mdu_pc;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb
            logic [PTR_W-1:0] w_off;
            logic             w_live;
            assign w_off      = PTR_W'(gi) - r_rd_ptr;
            assign w_live     = (CNT_W'(w_off) < r_count);
            assign w_hit1[gi] = w_live && (r_a3[gi] == q_a1);
            assign w_hit2[gi] = w_live && (r_a3[gi] == q_a2);
        end
    endgenerate

    assign q_busy1  = (q_a1 != 5'd0) && (|w_hit1);
    assign q_busy2  = (q_a2 != 5'd0) && (|w_hit2);

    assign regwrite = r_regwrite;
    assign A3       = r_A3;
    assign WD       = r_WD;
    assign pc       = r_pc_out;
    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign full     = (r_count == C_DEPTH);

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (reset && w_pop)
            $display("%d@%h: $%d <= %h", $time, r_pc[r_rd_ptr], r_a3[r_rd_ptr], r_wd[r_rd_ptr]);
    end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_grf_wb_buffer.sv
// ============================================================================
// Module   : tb_grf_wb_buffer
// Brief    : Self-checking bench for grf_wb_buffer against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_grf_wb_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, mdu_valid;
    logic              alu_ready, mdu_ready;
    logic [4:0]        alu_a3, mdu_a3;
    logic [DATA_W-1:0] alu_wd, alu_pc, mdu_wd, mdu_pc;
    logic              regwrite;
    logic [4:0]        A3;
    logic [DATA_W-1:0] WD, pc;
    logic [4:0]        q_a1, q_a2;
    logic              q_busy1, q_busy2;
    logic [2:0]        count;
    logic              empty, full;

    grf_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_a3(alu_a3),
        .alu_wd(alu_wd), .alu_pc(alu_pc),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_a3(mdu_a3),
        .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
        .regwrite(regwrite), .A3(A3), .WD(WD), .pc(pc),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]        a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } ent_t;

    ent_t              mq[$];
    logic              m_rw;
    logic [4:0]        m_a3;
    logic [DATA_W-1:0] m_wd, m_pc;

    function automatic bit m_alu_rdy();
        return (alu_a3 == 0) || (mq.size() < DEPTH);
    endfunction

    function automatic bit m_mdu_rdy();
        int f;
        f = DEPTH - mq.size();
        return (mdu_a3 == 0) || (f >= 2) || ((f >= 1) && !(alu_valid && alu_a3 != 0));
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].a3 == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_rw = 1'b0; m_a3 = '0; m_wd = '0; m_pc = '0;
    endtask

    // Advance one clock: the model consumes the inputs present at the edge.
    task automatic tick();
        bit   pa, pm;
        ent_t e;
        @(posedge clk);
        pa = alu_valid && (alu_a3 != 0) && m_alu_rdy();
        pm = mdu_valid && (mdu_a3 != 0) && m_mdu_rdy();
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_rw = 1'b1; m_a3 = e.a3; m_wd = e.wd; m_pc = e.pc;
        end else begin
            m_rw = 1'b0;
        end
        if (pa) mq.push_back('{alu_a3, alu_wd, alu_pc});
        if (pm) mq.push_back('{mdu_a3, mdu_wd, mdu_pc});
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 0; alu_a3 = 0; alu_wd = 0; alu_pc = 0;
        mdu_valid = 0; mdu_a3 = 0; mdu_wd = 0; mdu_pc = 0;
    endtask

    task automatic do_reset();
        idle();
        q_a1 = 0; q_a2 = 0;
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (regwrite !== 1'b0 || A3 !== 5'd0 || WD !== 32'd0 || pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rw=%b A3=%0d WD=%h pc=%h, want 0 0 0 0", regwrite, A3, WD, pc);
        end
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got count=%0d empty=%b full=%b, want 0 1 0", count, empty, full);
        end
    endtask

    task automatic test_single();
        idle();
        alu_valid = 1; alu_a3 = 5; alu_wd = 32'h1234; alu_pc = 32'h3000;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", alu_ready); end
        tick();
        idle();
        checks++;
        if (regwrite !== 1'b0 || count !== 3'd1) begin
            errors++; $display("FAIL single_edgeN: got rw=%b count=%0d want 0 1", regwrite, count);
        end
        tick();
        checks++;
        if (regwrite !== 1'b1 || A3 !== 5'd5 || WD !== 32'h1234 || pc !== 32'h3000 || empty !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got rw=%b A3=%0d WD=%h pc=%h empty=%b want 1 5 1234 3000 1",
                     regwrite, A3, WD, pc, empty);
        end
        tick();
        checks++;
        if (regwrite !== 1'b0 || A3 !== 5'd5) begin
            errors++; $display("FAIL single_oneshot: got rw=%b A3=%0d want 0 5", regwrite, A3);
        end
    endtask

    task automatic test_dual();
        idle();
        alu_valid = 1; alu_a3 = 3; alu_wd = 32'hA3; alu_pc = 32'h100;
        mdu_valid = 1; mdu_a3 = 4; mdu_wd = 32'hB4; mdu_pc = 32'h104;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || mdu_ready !== 1'b1) begin
            errors++; $display("FAIL dual_ready: got alu=%b mdu=%b want 1 1", alu_ready, mdu_ready);
        end
        tick();
        idle();
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL dual_count: got %0d want 2", count); end
        tick();
        checks++;
        if (regwrite !== 1'b1 || A3 !== 5'd3 || WD !== 32'hA3) begin
            errors++; $display("FAIL dual_first: got rw=%b A3=%0d WD=%h want 1 3 a3", regwrite, A3, WD);
        end
        tick();
        checks++;
        if (regwrite !== 1'b1 || A3 !== 5'd4 || WD !== 32'hB4 || pc !== 32'h104) begin
            errors++; $display("FAIL dual_second: got rw=%b A3=%0d WD=%h pc=%h want 1 4 b4 104", regwrite, A3, WD, pc);
        end
        tick();
        checks++;
        if (regwrite !== 1'b0) begin errors++; $display("FAIL dual_drain: got rw=%b want 0", regwrite); end
    endtask

    task automatic test_back_to_back();
        bit saw3 = 0;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_a3 = 5'(8 + i); alu_wd = $urandom; alu_pc = 32'(i * 8);
            mdu_valid = 1; mdu_a3 = 5'(16 + i); mdu_wd = $urandom; mdu_pc = 32'(i * 8 + 4);
            #1;
            checks++;
            if (count !== 3'(mq.size()) || alu_ready !== m_alu_rdy() || mdu_ready !== m_mdu_rdy()) begin
                errors++;
                $display("FAIL b2b_flow[%0d]: got count=%0d alu=%b mdu=%b want %0d %b %b",
                         i, count, alu_ready, mdu_ready, mq.size(), m_alu_rdy(), m_mdu_rdy());
            end
            if (mq.size() == 3) begin
                saw3 = 1;
                checks++;
                if (alu_ready !== 1'b1 || mdu_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_at3: got alu=%b mdu=%b want 1 0", alu_ready, mdu_ready);
                end
            end
            tick();
            checks++;
            if (regwrite !== m_rw || A3 !== m_a3 || WD !== m_wd) begin
                errors++; $display("FAIL b2b_issue[%0d]: got rw=%b A3=%0d WD=%h want %b %0d %h",
                                   i, regwrite, A3, WD, m_rw, m_a3, m_wd);
            end
        end
        checks++;
        if (!saw3) begin errors++; $display("FAIL b2b_reach3: occupancy 3 never reached, want reached"); end
        idle();
        repeat (5) tick();
    endtask

    task automatic test_zero_dest();
        idle();
        alu_valid = 1; alu_a3 = 0; alu_wd = 32'hffff;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", alu_ready); end
        tick();
        idle();
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL zero_count: got %0d want 0", count); end
        tick();
        checks++;
        if (regwrite !== 1'b0) begin errors++; $display("FAIL zero_issue: got rw=%b want 0", regwrite); end
    endtask

    task automatic test_scoreboard();
        idle();
        q_a1 = 7; q_a2 = 0;
        alu_valid = 1; alu_a3 = 7; alu_wd = 32'h77; alu_pc = 32'h200;
        #1;
        checks++;
        if (q_busy1 !== 1'b0) begin errors++; $display("FAIL sb_before: got %b want 0", q_busy1); end
        tick();
        idle();
        #1;
        checks++;
        if (q_busy1 !== 1'b1 || q_busy2 !== 1'b0) begin
            errors++; $display("FAIL sb_queued: got b1=%b b2=%b want 1 0", q_busy1, q_busy2);
        end
        tick();
        #1;
        checks++;
        if (q_busy1 !== 1'b0 || regwrite !== 1'b1 || A3 !== 5'd7) begin
            errors++; $display("FAIL sb_popped: got b1=%b rw=%b A3=%0d want 0 1 7", q_busy1, regwrite, A3);
        end
        q_a1 = 0;
        tick();
    endtask

    task automatic test_midreset();
        idle();
        alu_valid = 1; alu_a3 = 3; mdu_valid = 1; mdu_a3 = 4;
        tick();
        alu_a3 = 5; mdu_a3 = 6;
        tick();
        idle();
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL mid_fill: got count=%0d want 3", count); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (regwrite !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_reset: got rw=%b count=%0d empty=%b want 0 0 1", regwrite, count, empty);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (regwrite !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL mid_after: got rw=%b count=%0d want 0 0", regwrite, count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_a3    = 5'($urandom_range(0, 7));
            alu_wd    = $urandom;
            alu_pc    = $urandom;
            mdu_valid = ($urandom_range(0, 3) == 0);
            mdu_a3    = 5'($urandom_range(0, 7));
            mdu_wd    = $urandom;
            mdu_pc    = $urandom;
            q_a1      = 5'($urandom_range(0, 7));
            q_a2      = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (alu_ready !== m_alu_rdy() || mdu_ready !== m_mdu_rdy() ||
                count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
                q_busy1 !== m_busy(q_a1) || q_busy2 !== m_busy(q_a2)) begin
                errors++;
                $display("FAIL rand_comb[%0d]: got rdy=%b%b cnt=%0d e=%b f=%b busy=%b%b want rdy=%b%b cnt=%0d busy=%b%b",
                         i, alu_ready, mdu_ready, count, empty, full, q_busy1, q_busy2,
                         m_alu_rdy(), m_mdu_rdy(), mq.size(), m_busy(q_a1), m_busy(q_a2));
            end
            tick();
            checks++;
            if (regwrite !== m_rw || A3 !== m_a3 || WD !== m_wd || pc !== m_pc) begin
                errors++;
                $display("FAIL rand_issue[%0d]: got rw=%b A3=%0d WD=%h pc=%h want %b %0d %h %h",
                         i, regwrite, A3, WD, pc, m_rw, m_a3, m_wd, m_pc);
            end
        end
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_dual();
        test_back_to_back();
        test_zero_dest();
        test_scoreboard();
        test_midreset();
        do_reset();
        @(negedge clk);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
